mem8_arb: RTL and testbench

- Round-robin arbiter and access sequencer sharing one 8-bit x 128K single-port memory (1-cycle registered read) among NREQ requesters, e.g. instruction fetch, data-stack engine, UART loader.
- Presents one memory-side master port (we/ai/vi in, vo back); each requester sees a simple req/ack handshake with read data returned alongside ack.

---
 rtl/mem8_arb_if.sv | 29 ++
 rtl/mem8_arb.sv | 118 +++++++++++
 tb/tb_mem8_arb.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem8_arb_if.sv
// Requester and memory-side bus bundle for mem8_arb: per-requester req/ack handshake
// plus the single memory master port. slave = arbiter view, master = requesters + memory view.
interface mem8_arb_if #(
  parameter int NREQ = 2,
  parameter int AW   = 17,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] ai;
  logic [NREQ*DW-1:0] vi;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      vo;
  logic               busy;
  logic               m_we;
  logic [AW-1:0]      m_ai;
  logic [DW-1:0]      m_vi;
  logic [DW-1:0]      m_vo;

  modport slave (
    input  req, we, ai, vi, m_vo,
    output ack, vo, busy, m_we, m_ai, m_vi
  );

  modport master (
    output req, we, ai, vi, m_vo,
    input  ack, vo, busy, m_we, m_ai, m_vi
  );
endinterface

// File: rtl/mem8_arb.sv
// Arbiter/sequencer sharing one 8-bit single-port memory (1-cycle registered read) among NREQ requesters.
// Define MEM8_ARB_FIXPRI_EN for fixed priority (lowest index wins); default is round-robin.
module mem8_arb #(
  parameter int NREQ = 2,
  parameter int AW   = 17,
  parameter int DW   = 8
) (
  input  logic      clk,
  input  logic      rst,
  mem8_arb_if.slave bus
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ACC, RDW} state_t;

  state_t          state;
  logic [GW-1:0]   g;
  logic [GW-1:0]   win;
  logic [NREQ-1:0] ack_q;
  logic [DW-1:0]   vo_q;
  logic            busy_q;
  logic            m_we_q;
  logic [AW-1:0]   m_ai_q;
  logic [DW-1:0]   m_vi_q;

  // Winner among the current requests; only consumed in IDLE when |req.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
`ifdef MEM8_ARB_FIXPRI_EN
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) win = GW'(i);
    end
  end
`else
  logic [GW-1:0] rr;

  always_comb begin
    int  idx;
    logic found;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req[idx]) begin
        win   = GW'(idx);
        found = 1'b1;
      end
    end
  end

  // The pointer advances past the winner at the edge that issues its ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr <= '0;
    end else if ((state == ACC && m_we_q) || state == RDW) begin
      rr <= (g == GW'(NREQ - 1)) ? '0 : g + 1'b1;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: only control/bus registers are reset; there is no storage array here to clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      g      <= '0;
      ack_q  <= '0;
      vo_q   <= '0;
      busy_q <= 1'b0;
      m_we_q <= 1'b0;
      m_ai_q <= '0;
      m_vi_q <= '0;
    end else begin
      ack_q <= '0;
      unique case (state)
        IDLE: begin
          if (|bus.req) begin
            g      <= win;
            m_we_q <= bus.we[win];
            m_ai_q <= bus.ai[int'(win)*AW +: AW];
            m_vi_q <= bus.vi[int'(win)*DW +: DW];
            busy_q <= 1'b1;
            state  <= ACC;
          end
        end
        ACC: begin
          // m_we_q doubles as the latched write flag for the granted access.
          m_we_q <= 1'b0;
          if (m_we_q) begin
            ack_q[g] <= 1'b1;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end else begin
            state <= RDW;
          end
        end
        RDW: begin
          vo_q     <= bus.m_vo;
          ack_q[g] <= 1'b1;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack  = ack_q;
  assign bus.vo   = vo_q;
  assign bus.busy = busy_q;
  assign bus.m_we = m_we_q;
  assign bus.m_ai = m_ai_q;
  assign bus.m_vi = m_vi_q;

endmodule

// File: tb/tb_mem8_arb.sv
// Self-checking bench for mem8_arb: directed accesses, expected acks pushed to a scoreboard,
// a negedge monitor pops and compares every ack (requester, cycle, read data).
module tb_mem8_arb;
  localparam int NREQ = 2;
  localparam int AW   = 17;
  localparam int DW   = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem8_arb_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  mem8_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model: write on m_we, registered read of the presented address.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.m_we) mem[bus.m_ai] <= bus.m_vi;
    bus.m_vo <= mem[bus.m_ai];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NREQ-1:0] mask;
    bit              rd;
    logic [DW-1:0]   data;
    int              at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   acks  = 0;
  bit   watch = 1'b0;
  bit   saw_bad = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (watch && bus.m_ai == 17'h00020) saw_bad = 1'b1;
    if (rst && bus.ack != '0) begin
      acks++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ack: got %b expected none (cycle %0d)", bus.ack, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("ack_mask", 32'(bus.ack), 32'(mon_e.mask));
        check("ack_cycle", cyc, mon_e.at);
        if (mon_e.rd) check("read_data", 32'(bus.vo), 32'(mon_e.data));
      end
    end
  end

  task automatic set_fields(input int idx, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we[idx]         = w;
    bus.ai[idx*AW +: AW] = a;
    bus.vi[idx*DW +: DW] = d;
  endtask

  task automatic expect_ack(input int idx, input bit rd, input logic [DW-1:0] d, input int at);
    logic [NREQ-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    sb.push_back(exp_t'{mask: m, rd: rd, data: d, at: at});
  endtask

  // Called at a negedge; returns at the negedge where ack[idx] is visible.
  task automatic wait_ack(input int idx, input int budget);
    int n;
    n = 0;
    while (!bus.ack[idx] && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ack[idx]) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout: requester %0d got no ack expected one within %0d cycles", idx, budget);
    end
  endtask

  task automatic access(input int idx, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
    set_fields(idx, w, a, d);
    bus.req[idx] = 1'b1;
    expect_ack(idx, !w, exp_rd, cyc + (w ? 2 : 3));
    wait_ack(idx, 10);
    bus.req[idx] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time expired expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int start, n;
    mem[17'h00100] = 8'h11;
    mem[17'h00200] = 8'h22;
    mem[17'h00010] = 8'h3C;
    mem[17'h00020] = 8'hC3;
    bus.req = '0;
    bus.we  = '0;
    bus.ai  = '0;
    bus.vi  = '0;

    // Reset held with both requesters active.
    set_fields(0, 1'b0, 17'h00100, 8'h00);
    set_fields(1, 1'b0, 17'h00200, 8'h00);
    bus.req = 2'b11;
    #12;
    check("rst_ack", 32'(bus.ack), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_m_we", 32'(bus.m_we), 0);
    check("rst_m_ai", 32'(bus.m_ai), 0);
    check("rst_vo", 32'(bus.vo), 0);
    @(negedge clk);
    expect_ack(0, 1'b1, 8'h11, cyc + 3);
    expect_ack(1, 1'b1, 8'h22, cyc + 6);
    rst = 1'b1;
    wait_ack(0, 10);
    bus.req[0] = 1'b0;
    @(negedge clk);
    wait_ack(1, 10);
    bus.req[1] = 1'b0;
    @(negedge clk);

    // Single write: check the memory port during ACC, then read back.
    set_fields(0, 1'b1, 17'h1_2345, 8'hA5);
    bus.req[0] = 1'b1;
    expect_ack(0, 1'b0, 8'h00, cyc + 2);
    @(negedge clk);
    check("acc_m_we", 32'(bus.m_we), 1);
    check("acc_m_ai", 32'(bus.m_ai), 32'h12345);
    check("acc_m_vi", 32'(bus.m_vi), 32'hA5);
    check("acc_busy", 32'(bus.busy), 1);
    wait_ack(0, 10);
    bus.req[0] = 1'b0;
    @(negedge clk);
    check("idle_m_we", 32'(bus.m_we), 0);
    access(0, 1'b0, 17'h1_2345, 8'h00, 8'hA5);

    // Address change while the read is in flight must not leak.
    set_fields(1, 1'b0, 17'h00010, 8'h00);
    bus.req[1] = 1'b1;
    expect_ack(1, 1'b1, 8'h3C, cyc + 3);
    watch = 1'b1;
    @(negedge clk);
    check("mid_m_ai", 32'(bus.m_ai), 32'h00010);
    @(negedge clk);
    bus.ai[1*AW +: AW] = 17'h00020;
    wait_ack(1, 10);
    bus.req[1] = 1'b0;
    @(negedge clk);
    watch = 1'b0;
    check("mid_no_new_addr", 32'(saw_bad), 0);

    // Both requesters held: four reads.
    set_fields(0, 1'b0, 17'h00100, 8'h00);
    set_fields(1, 1'b0, 17'h00200, 8'h00);
    bus.req = 2'b11;
`ifdef MEM8_ARB_FIXPRI_EN
    expect_ack(0, 1'b1, 8'h11, cyc + 3);
    expect_ack(0, 1'b1, 8'h11, cyc + 6);
    expect_ack(0, 1'b1, 8'h11, cyc + 9);
    expect_ack(0, 1'b1, 8'h11, cyc + 12);
`else
    expect_ack(0, 1'b1, 8'h11, cyc + 3);
    expect_ack(1, 1'b1, 8'h22, cyc + 6);
    expect_ack(0, 1'b1, 8'h11, cyc + 9);
    expect_ack(1, 1'b1, 8'h22, cyc + 12);
`endif
    start = acks;
    n = 0;
    while (acks < start + 4 && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    bus.req = '0;
    check("rr_ack_count", acks - start, 4);
    @(negedge clk);

    // Async reset during RDW abandons the access.
    set_fields(0, 1'b0, 17'h00100, 8'h00);
    bus.req[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("rdw_busy", 32'(bus.busy), 1);
    rst = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_ack", 32'(bus.ack), 0);
    check("arst_m_we", 32'(bus.m_we), 0);
    @(negedge clk);
    bus.req = '0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_busy", 32'(bus.busy), 0);

    // Recovery at the top address.
    access(1, 1'b1, 17'h1_FFFF, 8'h5A, 8'h00);
    access(1, 1'b0, 17'h1_FFFF, 8'h00, 8'h5A);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
